seq_divider16: RTL and testbench



---
 rtl/seq_divider16_pkg.sv | 10 +
 rtl/seq_divider16_div_restore_step.sv | 26 ++
 rtl/seq_divider16.sv | 128 ++++++++++++
 tb/tb_seq_divider16.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider16_pkg.sv
// seq_divider16_pkg: shared state encoding and constants for the sequential divider
package seq_divider16_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic ZERO_DIV_BIT = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_divider16_div_restore_step.sv
// seq_divider16_div_restore_step: one combinational restoring-division iteration on a ripple subtract chain
module seq_divider16_div_restore_step
    import seq_divider16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] r_sh, b, t, c;
    assign r_sh = {r, q[WIDTH-1]};
    assign b = ~{1'b0, d};
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign t[i] = r_sh[i] ^ b[i] ^ c[i];
        if (i < WIDTH) begin : g_c
            assign c[i+1] = (r_sh[i] & b[i]) | (c[i] & (r_sh[i] ^ b[i]));
        end
    end
    // t[WIDTH] is the sign of R'-D; a kept remainder always fits in WIDTH bits
    assign r_next = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ~t[WIDTH]};
endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: multi-cycle restoring divider, one quotient bit per cycle; SIGNED_DIV_EN adds mode_signed
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SIGNED_DIV_EN
    input  logic             mode_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, r_step, q_step;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, op_a, op_b;
    logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, neg_q, neg_r;
`ifdef SIGNED_DIV_EN
    always_comb begin
        neg_q = mode_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r = mode_signed & dividend[WIDTH-1];
        op_a = (mode_signed & dividend[WIDTH-1]) ? -dividend : dividend;
        op_b = (mode_signed & divisor[WIDTH-1]) ? -divisor : divisor;
    end
`else
    always_comb begin
        neg_q = 1'b0;
        neg_r = 1'b0;
        op_a = dividend;
        op_b = divisor;
    end
`endif
    seq_divider16_div_restore_step #(.WIDTH(WIDTH)) u_step (
        .r(r_q),
        .q(q_q),
        .d(d_q),
        .r_next(r_step),
        .q_next(q_step)
    );
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        quot_d = quot_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        case (state_q)
            IDLE: if (start) begin
                if (divisor == '0) begin
                    state_d = DONE;
                    quot_d = {WIDTH{ZERO_DIV_BIT}};
                    rem_d = dividend;
                    dbz_d = 1'b1;
                end else begin
                    state_d = RUN;
                    count_d = CW'(WIDTH);
                    r_d = '0;
                    q_d = op_a;
                    d_d = op_b;
                    neg_q_d = neg_q;
                    neg_r_d = neg_r;
                end
            end
            RUN: begin
                r_d = r_step;
                q_d = q_step;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d = neg_q_q ? -q_step : q_step;
                    rem_d = neg_r_q ? -r_step : r_step;
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
            quot_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
            quot_q <= quot_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign quotient = quot_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: randomized self-checking bench against an arithmetic reference model
module tb_seq_divider16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic mode_s = 1'b0;
    logic [15:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [15:0] quotient, remainder;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider16 dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef SIGNED_DIV_EN
        .mode_signed(mode_s),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic ms,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa, sb;
        z = (b == 16'd0);
        if (z) begin
            q = 16'hFFFF;
            r = a;
        end else if (ms) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ms, input bit disturb);
        logic [15:0] eq, er;
        logic ez;
        int lat, nb;
        model(a, b, ms, eq, er, ez);
        @(negedge clk);
        dividend = a;
        divisor = b;
        mode_s = ms;
        start = 1'b1;
        lat = 0;
        nb = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (busy) nb++;
            if (done) break;
            if (disturb) begin
                start = 1'($urandom);
                dividend = 16'($urandom);
                divisor = 16'($urandom);
                mode_s = 1'($urandom);
            end
        end
        start = 1'b0;
        check("latency", lat, (b == 16'd0) ? 1 : 17);
        check("busy_cycles", nb, lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
        check("hold", {quotient, remainder}, {eq, er});
    endtask

    initial begin
        int lat, nd;
        logic [15:0] a, b;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        run_op(16'd100, 16'd7, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'd1, 1'b0, 1'b0);
        run_op(16'd3, 16'hFFFF, 1'b0, 1'b0);
        run_op(16'd5, 16'd0, 1'b0, 1'b0);
        run_op(16'd9, 16'd3, 1'b0, 1'b0);
        run_op(16'd1000, 16'd10, 1'b0, 1'b1);

        // reset lands on edge k+8 of a running 1000/10
        @(negedge clk);
        dividend = 16'd1000;
        divisor = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("no_done_after_rst", nd, 0);
        run_op(16'd17, 16'd4, 1'b0, 1'b0);

        // start held high: one op per WIDTH+2 cycles
        @(negedge clk);
        dividend = 16'd20;
        divisor = 16'd3;
        start = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("b2b_first", lat, 17);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        start = 1'b0;
        check("b2b_period", lat, 18);
        check("b2b_quot", quotient, 6);
        check("b2b_rem", remainder, 2);
        @(negedge clk);

`ifdef SIGNED_DIV_EN
        run_op(16'hFFF9, 16'd2, 1'b1, 1'b0);
        run_op(16'h8000, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'd7, 16'hFFFE, 1'b1, 1'b0);
        run_op(16'hFFF9, 16'd0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 :
                ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 255)) : 16'($urandom);
`ifdef SIGNED_DIV_EN
            run_op(a, b, 1'($urandom), 1'($urandom));
`else
            run_op(a, b, 1'b0, 1'($urandom));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
